inta_sequencer: RTL

INTA_SEQUENCER -- requirements
Module: inta_sequencer

---
 rtl/pic_pkg.sv | 20 ++
 rtl/isr_eoi_scan.sv | 31 +++
 rtl/inta_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt acknowledge sequencer.
package pic_pkg;

  localparam int IR_W  = 3;
  localparam int IRQ_N = 8;

  // After reset IR7 is the lowest priority, so IR0 is the highest.
  localparam logic [IR_W-1:0] LAST_SERVICED_RST = 3'b111;

  // Level reported for an acknowledge that has no live request behind it.
  localparam logic [IR_W-1:0] SPURIOUS_LEVEL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK1,
    ST_ACK2
  } state_e;

endpackage

// File: rtl/isr_eoi_scan.sv
// Finds the highest-priority set in-service bit. The scan starts just above
// the lowest-priority level and wraps around.
module isr_eoi_scan
  import pic_pkg::*;
(
  input  logic [IRQ_N-1:0] isr,
  input  logic [IR_W-1:0]  last_serviced,
  output logic [IR_W-1:0]  level,
  output logic             found
);

  logic [IR_W-1:0] idx;

  // Walk the levels in priority order and keep only the first set bit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    found = 1'b0;
    level = '0;
    idx   = '0;
    for (int i = 0; i < IRQ_N; i++) begin
      // The narrow add wraps modulo IRQ_N on its own.
      idx = last_serviced + IR_W'(i + 1);
      if (!found && isr[idx]) begin
        found = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/inta_sequencer.sv
// Interrupt acknowledge sequencer: raises int_out, runs the two-pulse INTA
// protocol, drives the vector byte and maintains the in-service register
// together with EOI handling and priority rotation.
module inta_sequencer
  import pic_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             intflag,
  input  logic [IR_W-1:0]  priority_id,
  input  logic             rotating_priority,
  input  logic             aeoi,
  input  logic [4:0]       vec_base,
  input  logic             inta_n,
  input  logic             eoi_valid,
  input  logic             eoi_specific,
  input  logic [IR_W-1:0]  eoi_level,
  input  logic             eoi_rotate,
  output logic             int_out,
  output logic [IRQ_N-1:0] isr,
  output logic [IR_W-1:0]  last_serviced,
  output logic [IRQ_N-1:0] irr_clear,
  output logic [7:0]       data_out,
  output logic             data_oe
);

  state_e           state_q;
  logic             inta_q;
  logic             int_out_q;
  logic [IRQ_N-1:0] isr_q, isr_d;
  logic [IR_W-1:0]  last_q, last_d;
  logic [IRQ_N-1:0] irr_clear_q;
  logic [7:0]       data_out_q;
  logic [IR_W-1:0]  level_q;
  logic             spurious_q;

  logic             inta_fall;
  logic             inta_rise;
  logic             ack_set;
  logic [IR_W-1:0]  scan_level;
  logic             scan_found;

  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;

  // A live request at the first INTA falling edge claims its level.
  assign ack_set = (state_q == ST_REQ) && inta_fall && intflag;

  // Non-specific EOI looks at isr before any same-cycle acknowledge set.
  isr_eoi_scan u_scan (
    .isr           (isr_q),
    .last_serviced (last_q),
    .level         (scan_level),
    .found         (scan_found)
  );

  // Next in-service bits and rotation point: automatic EOI, then the EOI
  // command, then the acknowledge set, so a set to the same bit wins.
  always_comb begin
    isr_d  = isr_q;
    last_d = last_q;

    if ((state_q == ST_ACK2) && inta_rise && aeoi && !spurious_q) begin
      isr_d[level_q] = 1'b0;
      if (rotating_priority) begin
        last_d = level_q;
      end
    end

    if (eoi_valid) begin
      if (eoi_specific) begin
        isr_d[eoi_level] = 1'b0;
        if (eoi_rotate) begin
          last_d = eoi_level;
        end
      end else if (scan_found) begin
        isr_d[scan_level] = 1'b0;
        if (eoi_rotate) begin
          last_d = scan_level;
        end
      end
    end

    if (ack_set) begin
      isr_d[priority_id] = 1'b1;
    end
  end

  // Acknowledge FSM with registered outputs and INTA edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      inta_q      <= 1'b1;
      int_out_q   <= 1'b0;
      isr_q       <= '0;
      last_q      <= LAST_SERVICED_RST;
      irr_clear_q <= '0;
      data_out_q  <= '0;
      level_q     <= SPURIOUS_LEVEL;
      spurious_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      inta_q      <= inta_n;
      isr_q       <= isr_d;
      last_q      <= last_d;
      irr_clear_q <= '0;

      unique case (state_q)
        ST_IDLE: begin
          if (intflag) begin
            state_q   <= ST_REQ;
            int_out_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (inta_fall) begin
            state_q   <= ST_ACK1;
            int_out_q <= 1'b0;
            if (intflag) begin
              level_q     <= priority_id;
              spurious_q  <= 1'b0;
              irr_clear_q <= IRQ_N'(1) << priority_id;
            end else begin
              level_q    <= SPURIOUS_LEVEL;
              spurious_q <= 1'b1;
            end
          end
        end
        ST_ACK1: begin
          if (inta_fall) begin
            state_q    <= ST_ACK2;
            data_out_q <= {vec_base, level_q};
          end
        end
        ST_ACK2: begin
          if (inta_rise) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign int_out       = int_out_q;
  assign isr           = isr_q;
  assign last_serviced = last_q;
  assign irr_clear     = irr_clear_q;
  assign data_out      = data_out_q;
  assign data_oe       = (state_q == ST_ACK2);

endmodule
